// File: rtl/quad_tuner.sv
// Encoder/button front end for the DDS core: synchronises the inputs, decodes x4 quadrature
// steps with velocity acceleration into a saturating tuning word, and cycles the waveform select.
module quad_tuner #(
    parameter int TW_BITS         = 11,
    parameter int TW_RESET        = 1,
    parameter int ACCEL_WINDOW    = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_WAVES       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               quadA,
    input  logic               quadB,
    input  logic               button,
    output logic [TW_BITS-1:0] tune_word,
    output logic [2:0]         wave_type,
    output logic               tune_changed,
    output logic [1:0]         accel_level
);

    localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW_BITS:0] TW_MAX = {1'b0, {TW_BITS{1'b1}}};

    logic [2:0] w_async;
    logic [1:0] w_sync_mid;
    logic [2:0] w_sync_old;

    assign w_async = {button, quadB, quadA};

    // Bit 0 of each shift register faces the asynchronous pin; decode uses bits 2 and 1.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [2:0] r_shift;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_shift <= '0;
            end else begin
                r_shift <= {r_shift[1:0], w_async[gi]};
            end
        end

        assign w_sync_old[gi] = r_shift[2];
        if (gi < 2) begin : g_mid
            assign w_sync_mid[gi] = r_shift[1];
        end
    end

    logic w_a_old, w_a_new, w_b_old, w_b_new, w_btn;
    assign w_a_old = w_sync_old[0];
    assign w_b_old = w_sync_old[1];
    assign w_a_new = w_sync_mid[0];
    assign w_b_new = w_sync_mid[1];
    assign w_btn   = w_sync_old[2];

    // A simultaneous A/B toggle cancels in the XOR and is ignored as illegal.
    logic w_event, w_dir_up;
    assign w_event  = w_a_old ^ w_a_new ^ w_b_old ^ w_b_new;
    assign w_dir_up = w_a_old ^ w_b_new;

    logic [GAP_W-1:0]   r_gap;
    logic [1:0]         r_level;
    logic               r_last_dir;
    logic [TW_BITS-1:0] r_tune_word;
    logic               r_tune_changed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap <= GAP_W'(ACCEL_WINDOW);
        end else if (w_event) begin
            r_gap <= '0;
        end else if (r_gap < GAP_W'(ACCEL_WINDOW)) begin
            r_gap <= r_gap + 1'b1;
        end
    end

    logic [1:0] w_level_next;
    always_comb begin
        w_level_next = 2'd0;
        if ((r_gap < GAP_W'(ACCEL_WINDOW)) && (w_dir_up == r_last_dir)) begin
            w_level_next = (r_level == 2'd3) ? 2'd3 : r_level + 2'd1;
        end
    end

    // One extra bit of headroom exposes overflow on the way up and borrow on the way down.
    logic [TW_BITS:0]   w_step, w_sum, w_diff;
    logic [TW_BITS-1:0] w_tune_calc;
    assign w_step = (TW_BITS + 1)'(1) << {w_level_next, 1'b0};
    assign w_sum  = {1'b0, r_tune_word} + w_step;
    assign w_diff = {1'b0, r_tune_word} - w_step;

    always_comb begin
        w_tune_calc = r_tune_word;
        if (w_dir_up) begin
            w_tune_calc = (w_sum > TW_MAX) ? TW_MAX[TW_BITS-1:0] : w_sum[TW_BITS-1:0];
        end else begin
            w_tune_calc = w_diff[TW_BITS] ? '0 : w_diff[TW_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tune_word    <= TW_BITS'(TW_RESET);
            r_tune_changed <= 1'b0;
            r_level        <= 2'd0;
            r_last_dir     <= 1'b0;
        end else begin
            r_tune_changed <= 1'b0;
            if (w_event) begin
                r_level        <= w_level_next;
                r_last_dir     <= w_dir_up;
                r_tune_word    <= w_tune_calc;
                r_tune_changed <= (w_tune_calc != r_tune_word);
            end
        end
    end

    logic            r_db;
    logic [DB_W-1:0] r_db_cnt;
    logic [2:0]      r_wave;

    // The debounced level flips on the last of DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db     <= 1'b0;
            r_db_cnt <= '0;
            r_wave   <= 3'd0;
        end else if (w_btn != r_db) begin
            if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db     <= w_btn;
                r_db_cnt <= '0;
                if (w_btn) begin
                    r_wave <= (r_wave == 3'(NUM_WAVES - 1)) ? 3'd0 : r_wave + 3'd1;
                end
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign tune_word    = r_tune_word;
    assign tune_changed = r_tune_changed;
    assign accel_level  = r_level;
    assign wave_type    = r_wave;

endmodule
